// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding and sizing constants.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam int WORD_BYTES      = 4;
    localparam int MAX_WAIT_CYCLES = 15;
    localparam int WAIT_CNT_W      = $clog2(MAX_WAIT_CYCLES + 1);

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port 32-bit word RAM with per-byte write enable and registered read.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [WORD_BYTES-1:0] be,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**DEPTH_LOG2];

    // Read data register only updates on enabled loads, so it holds across the response phase.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < WORD_BYTES; i++) begin
                    if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Wait-state data-memory responder for the MEM stage; optional byte strobes via DMEM_BYTE_STROBE_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
`ifdef DMEM_BYTE_STROBE_EN
    input  logic [3:0]  req_be,
`endif
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        WAIT_CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_t                  state;
    logic [WAIT_CNT_W-1:0]   wait_cnt;
    logic                    rd_ok;
    logic                    wr_q;
    logic [31:0]             addr_q;
    logic [31:0]             wdata_q;
    logic [WORD_BYTES-1:0]   be_q;
    logic                    addr_err;
    logic                    ram_en;
    logic [31:0]             ram_rdata;

    // Request fields are plain data: captured on acceptance, never reset.
    always_ff @(posedge clk) begin
        if (req_ready && req_valid) begin
            wr_q    <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

`ifdef DMEM_BYTE_STROBE_EN
    always_ff @(posedge clk) begin
        if (req_ready && req_valid) be_q <= req_be;
    end
`else
    assign be_q = '1;
`endif

    assign addr_err = (addr_q[1:0] != 2'b00) || ((addr_q >> (DEPTH_LOG2 + 2)) != 32'd0);
    assign ram_en   = (state == ACCESS) && !addr_err;

    // rd_ok is only set in RESP for clean loads, so stores, errors and idle all read as zero.
    assign rsp_rdata = rd_ok ? ram_rdata : 32'd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rd_ok     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (WAIT_CYCLES > 0) begin
                            state    <= WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end else begin
                            state <= ACCESS;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == '0) state <= ACCESS;
                    else                wait_cnt <= wait_cnt - 1'b1;
                end
                ACCESS: begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_err   <= addr_err;
                    rd_ok     <= !wr_q && !addr_err;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rd_ok     <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    dmem_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk  (clk),
        .en   (ram_en),
        .we   (wr_q),
        .be   (be_q),
        .addr (addr_q[DEPTH_LOG2+1:2]),
        .wdata(wdata_q),
        .rdata(ram_rdata)
    );

endmodule
